div_hs_bridge: RTL and testbench
================================

Name: div_hs_bridge

Overview:
- Upstream feeder for the ha3 signed divider.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the divider over its 4-phase REQ/ACK handshake, then captures Q, R and FDBZ into a result register presented on a valid/ready output stream.
- Converts the streaming pipeline protocol to the divider's level-sensitive handshake without losing or reordering operations.

Parameters:
- W, 16, operand/result width (signed two's complement)
- DEPTH, 4, operand FIFO entries (power of two, >=2)

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- IN_VALID  in  1  operand pair valid
- IN_READY  out  1  FIFO can accept; equals (CNT < DEPTH)
- IN_A  in  W  dividend
- IN_D  in  W  divisor
- REQ  out  1  request to divider, registered
- A  out  W  dividend to divider, registered
- D  out  W  divisor to divider, registered
- ACK  in  1  divider acknowledge (same clock domain, no synchronizer)
- Q  in  W  divider quotient
- R  in  W  divider remainder
- FDBZ  in  1  divider divide-by-zero flag
- OUT_VALID  out  1  result register full
- OUT_READY  in  1  consumer takes result
- OUT_Q  out  W  captured quotient
- OUT_R  out  W  captured remainder
- OUT_DBZ  out  1  captured FDBZ
- CNT  out  $clog2(DEPTH+1)  FIFO occupancy
- ISSUED  out  16  count of REQ rising edges, wraps at 0xFFFF->0

Behaviour:
- Reset (RST=1 at posedge):
  - state=IDLE; FIFO emptied; CNT=0.
  - REQ=0, A=0, D=0.
  - OUT_VALID=0, OUT_Q=0, OUT_R=0, OUT_DBZ=0, ISSUED=0.
  - Reset in any state aborts the operation in flight; its result is discarded. The divider shares RST.
- Push: occurs at posedge when IN_VALID&&IN_READY. IN_READY depends only on the registered CNT, so a pop in the same cycle does not raise IN_READY that cycle.
- Simultaneous push and pop: CNT unchanged; pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RELEASE.
- IDLE:
  - Issue condition: CNT>0 && OUT_VALID==0 && ACK==0.
  - On issue: pop head into A/D, REQ<=1, ISSUED++, go to ISSUE.
  - Otherwise REQ=0 and A/D hold 0.
- ISSUE:
  - REQ, A and D are held stable.
  - When ACK==1 is sampled: OUT_Q<=Q, OUT_R<=R, OUT_DBZ<=FDBZ, OUT_VALID<=1; REQ<=0, A<=0, D<=0; go to RELEASE.
- RELEASE:
  - REQ=0.
  - When ACK==0 is sampled, go to IDLE.
  - A new request never starts while ACK is still high.
- Output stream:
  - OUT_VALID clears at the posedge where OUT_VALID&&OUT_READY.
  - OUT_Q/R/DBZ hold their values until the next capture.
  - Only one result is held. The next issue waits until OUT_VALID==0, which provides back-pressure to the divider.
- Latency:
  - Push accepted at edge N with FIFO empty and idle: REQ=1 visible after edge N+1.
  - ACK sampled high at edge M: OUT_VALID=1 and REQ=0 after edge M.
  - Minimum spacing between REQ rising edges: 2 cycles after ACK falls.
- Arithmetic: none. Q/R/FDBZ pass through unmodified, including 0x8000 / 0xFFFF and divide-by-zero cases.
- ACK high while in IDLE (protocol violation or post-reset residue): ignored; no issue until ACK==0.
- Ordering: results leave in push order.

Test Plan:
- Reset: hold RST=1 for 2 cycles mid-stream -> REQ=0, A=D=0, OUT_VALID=0, CNT=0, IN_READY=1, ISSUED=0.
- Single op: push A=0x0064, D=0x0009; the model divider ACKs 3 cycles after REQ with Q=11, R=1 ->
  - REQ rises the cycle after the push, with A/D=0064/0009 until ACK.
  - OUT_VALID=1 with OUT_Q=11, OUT_R=1, OUT_DBZ=0.
  - REQ falls at the same edge as the capture.
- Divide by zero: push A=0x0001, D=0x0000; the model returns FDBZ=1, Q=0xFFFF, R=0x0001 -> OUT_DBZ=1 and OUT_Q/OUT_R pass through unchanged.
- Back-pressure: OUT_READY=0, push 6 pairs back-to-back ->
  - CNT reaches 4 and IN_READY=0 once the FIFO is full; exactly 5 pushes are accepted (the first is popped for issue).
  - ISSUED=1 until OUT_READY=1, then the remaining pairs drain in order.
- Slow release: the model keeps ACK high 5 cycles after REQ falls -> REQ stays 0 until the cycle after ACK is sampled low, then the next REQ rises.
- Reset mid-operation: RST=1 while in ISSUE with 2 entries queued -> after the edge REQ=0, CNT=0, OUT_VALID=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/div_hs_bridge.sv
// Stream-to-handshake feeder for the ha3 signed divider: operand FIFO, 4-phase REQ/ACK issue,
// and a single-entry result register on a valid/ready output stream.
module div_hs_bridge #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [W-1:0]                 IN_A,
    input  logic [W-1:0]                 IN_D,
    output logic                         REQ,
    output logic [W-1:0]                 A,
    output logic [W-1:0]                 D,
    input  logic                         ACK,
    input  logic [W-1:0]                 Q,
    input  logic [W-1:0]                 R,
    input  logic                         FDBZ,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [W-1:0]                 OUT_Q,
    output logic [W-1:0]                 OUT_R,
    output logic                         OUT_DBZ,
    output logic [$clog2(DEPTH+1)-1:0]   CNT,
    output logic [15:0]                  ISSUED
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          state_r;
    logic [2*W-1:0]  mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   cnt_r;
    logic            req_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    d_r;
    logic            out_valid_r;
    logic [W-1:0]    out_q_r;
    logic [W-1:0]    out_r_r;
    logic            out_dbz_r;
    logic [15:0]     issued_r;

    logic            in_ready_s;
    logic            push_s;
    logic            pop_s;
    logic [W-1:0]    head_a_s;
    logic [W-1:0]    head_d_s;

    // Accept/issue decisions; ACK still high from a previous op blocks a new issue.
    always_comb begin
        in_ready_s = (cnt_r < DEPTH_C);
        push_s     = IN_VALID && in_ready_s;
        pop_s      = (state_r == S_IDLE) && (cnt_r != {CW{1'b0}}) && !out_valid_r && !ACK;
        head_a_s   = mem_r[rd_ptr_r][2*W-1:W];
        head_d_s   = mem_r[rd_ptr_r][W-1:0];
    end

    // Operand storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {IN_A, IN_D};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Handshake FSM with result capture and output-stream drain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= S_IDLE;
            req_r       <= 1'b0;
            a_r         <= {W{1'b0}};
            d_r         <= {W{1'b0}};
            out_valid_r <= 1'b0;
            out_q_r     <= {W{1'b0}};
            out_r_r     <= {W{1'b0}};
            out_dbz_r   <= 1'b0;
            issued_r    <= 16'd0;
        end else begin
            if (out_valid_r && OUT_READY) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        a_r      <= head_a_s;
                        d_r      <= head_d_s;
                        req_r    <= 1'b1;
                        issued_r <= issued_r + 16'd1;
                        state_r  <= S_ISSUE;
                    end else begin
                        req_r <= 1'b0;
                        a_r   <= {W{1'b0}};
                        d_r   <= {W{1'b0}};
                    end
                end
                S_ISSUE: begin
                    if (ACK) begin
                        out_q_r     <= Q;
                        out_r_r     <= R;
                        out_dbz_r   <= FDBZ;
                        out_valid_r <= 1'b1;
                        req_r       <= 1'b0;
                        a_r         <= {W{1'b0}};
                        d_r         <= {W{1'b0}};
                        state_r     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    req_r <= 1'b0;
                    if (!ACK) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    req_r   <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_s;
    assign REQ       = req_r;
    assign A         = a_r;
    assign D         = d_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_Q     = out_q_r;
    assign OUT_R     = out_r_r;
    assign OUT_DBZ   = out_dbz_r;
    assign CNT       = cnt_r;
    assign ISSUED    = issued_r;

endmodule

// File: tb/tb_div_hs_bridge.sv
// Directed bench for div_hs_bridge with a behavioural divider that answers REQ after 3 cycles
// and holds ACK for a programmable number of cycles after REQ falls.
module tb_div_hs_bridge;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_d;
    logic          req;
    logic [W-1:0]  a;
    logic [W-1:0]  d;
    logic          ack_m;
    logic [W-1:0]  q_m;
    logic [W-1:0]  r_m;
    logic          fdbz_m;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_q;
    logic [W-1:0]  out_r;
    logic          out_dbz;
    logic [2:0]    cnt;
    logic [15:0]   issued;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs [6];
    vec_t bp   [6];

    int vec_cnt    = 0;
    int err_cnt    = 0;
    int ack_hold   = 0;
    int dly        = 0;
    int hold       = 0;
    int exp_issued = 0;

    div_hs_bridge #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK(clk), .RST(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_A(in_a), .IN_D(in_d),
        .REQ(req), .A(a), .D(d), .ACK(ack_m), .Q(q_m), .R(r_m), .FDBZ(fdbz_m),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_Q(out_q), .OUT_R(out_r), .OUT_DBZ(out_dbz),
        .CNT(cnt), .ISSUED(issued)
    );

    always #5 clk = ~clk;

    // Reference divider: {dbz, q, r}; divide-by-zero returns q=all-ones, r=dividend.
    function automatic logic [32:0] div_model(input logic [15:0] av, input logic [15:0] dv);
        int ai;
        int di;
        int qi;
        int ri;
        if (dv == 16'h0000) begin
            return {1'b1, 16'hFFFF, av};
        end
        ai = int'($signed(av));
        di = int'($signed(dv));
        qi = ai / di;
        ri = ai % di;
        return {1'b0, qi[15:0], ri[15:0]};
    endfunction

    // Behavioural divider on the 4-phase handshake.
    always @(posedge clk) begin
        if (rst) begin
            ack_m  <= 1'b0;
            q_m    <= 16'h0000;
            r_m    <= 16'h0000;
            fdbz_m <= 1'b0;
            dly    <= 0;
            hold   <= 0;
        end else if (!ack_m) begin
            hold <= 0;
            if (req) begin
                if (dly >= 2) begin
                    ack_m                 <= 1'b1;
                    {fdbz_m, q_m, r_m}    <= div_model(a, d);
                    dly                   <= 0;
                end else begin
                    dly <= dly + 1;
                end
            end else begin
                dly <= 0;
            end
        end else if (!req) begin
            if (hold >= ack_hold) begin
                ack_m <= 1'b0;
            end else begin
                hold <= hold + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int got;
        int n;
        bit took;
        bit bad;

        vecs[0] = '{16'h0064, 16'h0009, 16'h000B, 16'h0001, 1'b0};
        vecs[1] = '{16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 1'b1};
        vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0};
        vecs[4] = '{16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0};
        vecs[5] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0};

        bp[0] = '{16'h0064, 16'h0003, 16'h0021, 16'h0001, 1'b0};
        bp[1] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
        bp[2] = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0};
        bp[3] = '{16'h0010, 16'h0000, 16'hFFFF, 16'h0010, 1'b1};
        bp[4] = '{16'h7FFF, 16'h0002, 16'h3FFF, 16'h0001, 1'b0};
        bp[5] = '{16'h0005, 16'h0005, 16'h0001, 16'h0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0000; in_d = 16'h0000; out_ready = 1'b0;
        repeat (2) tick();
        check("rst_req", {31'd0, req}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cnt", {29'd0, cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_issued", {16'd0, issued}, 32'd0);
        rst = 1'b0;
        tick();

        // Single operations, one at a time, with latency checks.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_a = vecs[i].a; in_d = vecs[i].d;
            tick();
            in_valid = 1'b0;
            check("push_cnt", {29'd0, cnt}, 32'd1);
            check("push_req_low", {31'd0, req}, 32'd0);
            tick();
            exp_issued++;
            check("issue_req", {31'd0, req}, 32'd1);
            check("issue_a", {16'd0, a}, {16'd0, vecs[i].a});
            check("issue_d", {16'd0, d}, {16'd0, vecs[i].d});
            check("issue_cnt", {29'd0, cnt}, 32'd0);
            check("issue_count", {16'd0, issued}, exp_issued);
            wait_out("single");
            check("capture_req_low", {31'd0, req}, 32'd0);
            check("single_q", {16'd0, out_q}, {16'd0, vecs[i].q});
            check("single_r", {16'd0, out_r}, {16'd0, vecs[i].r});
            check("single_dbz", {31'd0, out_dbz}, {31'd0, vecs[i].dbz});
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("consume_clear", {31'd0, out_valid}, 32'd0);
            repeat (3) tick();
        end

        // Back-pressure: six offered back-to-back, five fit.
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_a = bp[acc].a; in_d = bp[acc].d;
            took = in_ready;
            tick();
            if (took) acc++;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 32'd5);
        check("bp_cnt_full", {29'd0, cnt}, 32'd4);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (12) tick();
        check("bp_issued_once", {16'd0, issued}, exp_issued + 1);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_held_q", {16'd0, out_q}, {16'd0, bp[0].q});
        out_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 5 && n < 200) begin
            if (out_valid) begin
                check("drain_q", {16'd0, out_q}, {16'd0, bp[got].q});
                check("drain_r", {16'd0, out_r}, {16'd0, bp[got].r});
                check("drain_dbz", {31'd0, out_dbz}, {31'd0, bp[got].dbz});
                got++;
            end
            tick();
            n++;
        end
        exp_issued += 5;
        check("drain_count", got, 32'd5);
        check("drain_issued", {16'd0, issued}, exp_issued);
        check("drain_cnt", {29'd0, cnt}, 32'd0);
        repeat (6) tick();

        // Slow release: ACK stays high 5 cycles after REQ falls.
        ack_hold = 5;
        in_valid = 1'b1; in_a = vecs[0].a; in_d = vecs[0].d;
        tick();
        in_a = vecs[3].a; in_d = vecs[3].d;
        tick();
        in_valid = 1'b0;
        wait_out("slow_first");
        check("slow_first_q", {16'd0, out_q}, {16'd0, vecs[0].q});
        bad = 1'b0;
        n = 0;
        while (ack_m && n < 20) begin
            if (req) bad = 1'b1;
            tick();
            n++;
        end
        check("slow_req_low_while_ack", {31'd0, bad}, 32'd0);
        check("slow_ack_cycles", n, 32'd6);
        check("slow_req_at_ack_fall", {31'd0, req}, 32'd0);
        tick();
        check("slow_req_still_low", {31'd0, req}, 32'd0);
        tick();
        check("slow_req_rise", {31'd0, req}, 32'd1);
        check("slow_second_a", {16'd0, a}, {16'd0, vecs[3].a});
        wait_out("slow_second");
        check("slow_second_q", {16'd0, out_q}, {16'd0, vecs[3].q});
        exp_issued += 2;
        check("slow_issued", {16'd0, issued}, exp_issued);
        repeat (12) tick();
        ack_hold = 0;

        // Reset while in ISSUE with two operands queued.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_a = vecs[k].a; in_d = vecs[k].d;
            tick();
        end
        in_valid = 1'b0;
        check("midop_req", {31'd0, req}, 32'd1);
        check("midop_cnt", {29'd0, cnt}, 32'd2);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("mrst_req", {31'd0, req}, 32'd0);
        check("mrst_ad", {a, d}, 32'd0);
        check("mrst_cnt", {29'd0, cnt}, 32'd0);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_issued", {16'd0, issued}, 32'd0);
        bad = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (out_valid || req) bad = 1'b1;
        end
        check("mrst_no_stale", {31'd0, bad}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
